// File: rtl/cordic_ln_iter_ctrl_pkg.sv
// Shared constants for the CORDIC LN iteration controller: iteration limits,
// repeated shift indices and the float32 atanh(2^-i) table.
package cordic_ln_iter_ctrl_pkg;

  localparam int          W_FP     = 32;
  localparam logic [4:0]  MAX_ITER = 5'd16;
  localparam logic [4:0]  REP_A    = 5'd4;
  localparam logic [4:0]  REP_B    = 5'd13;

  typedef enum logic {
    REP_DONE = 1'b0,
    REP_PEND = 1'b1
  } rep_state_t;

  // float32 of atanh(2^-i), round-to-nearest-even; indices 0 and 15 are never addressed
  function automatic logic [W_FP-1:0] atanh_lut(input logic [3:0] idx);
    case (idx)
      4'd1:    atanh_lut = 32'h3F0C9F54;
      4'd2:    atanh_lut = 32'h3E82C578;
      4'd3:    atanh_lut = 32'h3E00AC49;
      4'd4:    atanh_lut = 32'h3D802AC4;
      4'd5:    atanh_lut = 32'h3D000AAC;
      4'd6:    atanh_lut = 32'h3C8002AB;
      4'd7:    atanh_lut = 32'h3C0000AB;
      4'd8:    atanh_lut = 32'h3B80002B;
      4'd9:    atanh_lut = 32'h3B00000B;
      4'd10:   atanh_lut = 32'h3A800003;
      4'd11:   atanh_lut = 32'h3A000001;
      4'd12:   atanh_lut = 32'h39800000;
      4'd13:   atanh_lut = 32'h39000000;
      4'd14:   atanh_lut = 32'h38800000;
      default: atanh_lut = 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_ln_iter_ctrl_atanh_rom.sv
// Registered atanh constant ROM; the reset value is the i=1 entry so the
// output is valid as soon as reset is released.
module cordic_ln_iter_ctrl_atanh_rom
  import cordic_ln_iter_ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_LN,
  input  logic [3:0]      addr,
  output logic [W_FP-1:0] data
);

  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) data <= atanh_lut(4'd1);
    else        data <= atanh_lut(addr);
  end

endmodule

// File: rtl/cordic_ln_iter_ctrl.sv
// Iteration controller for the hyperbolic-vectoring CORDIC LN datapath:
// counts iterations, sequences shift indices (repeating 4 and 13) and latches direction.
module cordic_ln_iter_ctrl
  import cordic_ln_iter_ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_LN,
  input  logic            RST,
  input  logic            CLK_CDIR,
  input  logic            Y_SIGN,
  output logic [4:0]      CONT_ITER,
  output logic [4:0]      SHIFT_I,
  output logic [W_FP-1:0] LUT_ATANH,
  output logic            DIR,
  output logic            ITER_DONE,
  output logic            STRB_ERR
);

  rep_state_t rep_q, rep_d;
  logic [4:0] cnt_d, shift_d;
  logic       dir_d, done_d, err_d;

  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) begin
      CONT_ITER <= 5'd0;
      SHIFT_I   <= 5'd1;
      rep_q     <= REP_PEND;
      DIR       <= 1'b0;
      ITER_DONE <= 1'b0;
      STRB_ERR  <= 1'b0;
    end else begin
      CONT_ITER <= cnt_d;
      SHIFT_I   <= shift_d;
      rep_q     <= rep_d;
      DIR       <= dir_d;
      ITER_DONE <= done_d;
      STRB_ERR  <= err_d;
    end
  end

  always_comb begin
    cnt_d   = CONT_ITER;
    shift_d = SHIFT_I;
    rep_d   = rep_q;
    dir_d   = DIR;
    err_d   = STRB_ERR;
    if (RST) begin
      cnt_d   = 5'd0;
      shift_d = 5'd1;
      rep_d   = REP_PEND;
      dir_d   = 1'b0;
      err_d   = 1'b0;
    end else if (CLK_CDIR) begin
      if (CONT_ITER < MAX_ITER) begin
        dir_d = Y_SIGN;
        cnt_d = CONT_ITER + 5'd1;
        // the final advance leaves the index parked at 14
        if (cnt_d != MAX_ITER) begin
          if ((SHIFT_I == REP_A || SHIFT_I == REP_B) && rep_q == REP_PEND) begin
            rep_d = REP_DONE;
          end else begin
            shift_d = SHIFT_I + 5'd1;
            rep_d   = REP_PEND;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
    done_d = (cnt_d == MAX_ITER);
  end

  // addressing with the next index makes LUT_ATANH change together with SHIFT_I
  cordic_ln_iter_ctrl_atanh_rom u_rom (
    .CLK    (CLK),
    .RST_LN (RST_LN),
    .addr   (shift_d[3:0]),
    .data   (LUT_ATANH)
  );

endmodule

// File: tb/tb_cordic_ln_iter_ctrl.sv
// Scoreboard bench for cordic_ln_iter_ctrl: expectations are queued as
// stimulus is driven and compared against the DUT after each clock edge.
module tb_cordic_ln_iter_ctrl;

  logic        CLK = 1'b0;
  logic        RST_LN, RST, CLK_CDIR, Y_SIGN;
  logic [4:0]  CONT_ITER, SHIFT_I;
  logic [31:0] LUT_ATANH;
  logic        DIR, ITER_DONE, STRB_ERR;

  cordic_ln_iter_ctrl dut (
    .CLK       (CLK),
    .RST_LN    (RST_LN),
    .RST       (RST),
    .CLK_CDIR  (CLK_CDIR),
    .Y_SIGN    (Y_SIGN),
    .CONT_ITER (CONT_ITER),
    .SHIFT_I   (SHIFT_I),
    .LUT_ATANH (LUT_ATANH),
    .DIR       (DIR),
    .ITER_DONE (ITER_DONE),
    .STRB_ERR  (STRB_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  cnt;
    logic [4:0]  shift;
    logic [31:0] lut;
    logic        dir;
    logic        done;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // required index sequence, one entry per completed-iteration count 0..15
  int seq [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

  int   m_pos;
  logic m_dir, m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, req);
    end
  endtask

  // float32 of atanh(2^-i) from real arithmetic, round-to-nearest-even
  function automatic logic [31:0] atanh_bits(input int i);
    real x, v, frac, rem;
    int  r;
    logic [7:0]  e;
    logic [22:0] m;
    x    = 1.0 / (2.0 ** i);
    v    = 0.5 * $ln((1.0 + x) / (1.0 - x));
    frac = (v * (2.0 ** i) - 1.0) * 8388608.0;
    r    = $rtoi(frac);
    rem  = frac - r;
    if (rem > 0.5 || (rem == 0.5 && (r % 2) == 1)) r++;
    e = 8'(127 - i);
    m = 23'(r);
    return {1'b0, e, m};
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    int   s;
    s       = seq[(m_pos < 16) ? m_pos : 15];
    e.cnt   = 5'(m_pos);
    e.shift = 5'(s);
    e.lut   = atanh_bits(s);
    e.dir   = m_dir;
    e.done  = (m_pos == 16);
    e.err   = m_err;
    return e;
  endfunction

  task automatic model_clear();
    m_pos = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_strobe(input logic ys);
    if (m_pos < 16) begin
      m_dir = ys;
      m_pos++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic compare_outputs(input string t);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({t, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({t, ".cont_iter"}, 32'(CONT_ITER), 32'(e.cnt));
    check({t, ".shift_i"},   32'(SHIFT_I),   32'(e.shift));
    check({t, ".lut_atanh"}, LUT_ATANH,      e.lut);
    check({t, ".dir"},       32'(DIR),       32'(e.dir));
    check({t, ".iter_done"}, 32'(ITER_DONE), 32'(e.done));
    check({t, ".strb_err"},  32'(STRB_ERR),  32'(e.err));
  endtask

  // n back-to-back strobe cycles; Y_SIGN alternates starting from ys0
  task automatic strobes(input string t, input int n, input logic ys0);
    logic ys;
    ys = ys0;
    @(negedge CLK);
    for (int k = 0; k < n; k++) begin
      CLK_CDIR = 1'b1;
      Y_SIGN   = ys;
      model_strobe(ys);
      exp_q.push_back(model_now());
      @(negedge CLK);
      compare_outputs(t);
      ys = ~ys;
    end
    CLK_CDIR = 1'b0;
  endtask

  task automatic sync_clear(input string t, input logic with_strobe);
    @(negedge CLK);
    RST      = 1'b1;
    CLK_CDIR = with_strobe;
    Y_SIGN   = 1'b1;
    model_clear();
    exp_q.push_back(model_now());
    @(negedge CLK);
    RST      = 1'b0;
    CLK_CDIR = 1'b0;
    compare_outputs(t);
  endtask

  initial begin
    RST_LN = 1'b0; RST = 1'b0; CLK_CDIR = 1'b0; Y_SIGN = 1'b0;
    model_clear();

    // T1: asynchronous reset, then idle
    #2 RST_LN = 1'b1;
    #11 RST_LN = 1'b0;
    repeat (10) @(negedge CLK);
    exp_q.push_back(model_now());
    compare_outputs("t1_reset");

    // T2/T3: full run, strobes 3 cycles apart, alternating Y_SIGN, holds checked between
    sync_clear("t2_rst", 1'b0);
    for (int s = 0; s < 16; s++) begin
      strobes("t2_step", 1, (s % 2 == 0) ? 1'b1 : 1'b0);
      Y_SIGN = ~Y_SIGN;
      @(negedge CLK);
      @(negedge CLK);
      exp_q.push_back(model_now());
      compare_outputs("t3_hold");
    end

    // T4: strobe at saturation, then clear
    strobes("t4_sat", 1, ~m_dir);
    sync_clear("t4_clr", 1'b0);

    // T5: clear and strobe in the same cycle
    strobes("t5_pre", 5, 1'b1);
    sync_clear("t5_clr_strobe", 1'b1);

    // T6: asynchronous reset mid-cycle, then back-to-back strobes
    strobes("t6_pre", 7, 1'b0);
    @(posedge CLK);
    #2 RST_LN = 1'b1;
    #1;
    model_clear();
    exp_q.push_back(model_now());
    compare_outputs("t6_async");
    @(negedge CLK);
    RST_LN = 1'b0;
    strobes("t6_b2b", 6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
